// File: rtl/incr_count_pkg.sv
// rtl/incr_count_pkg.sv - shared types and constants for the incr_count_ctrl counter stage
package incr_count_pkg;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] TERM_DEFAULT_VAL = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    HOLD  = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/increment_by_1.sv
// rtl/increment_by_1.sv - 4-bit combinational +1 incrementer with carry-out and signed overflow
module increment_by_1
  import incr_count_pkg::*;
(
  input  logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] s,
  output logic             carry,
  output logic             overflow
);

  // Unsigned sum with carry-out; signed overflow is a positive operand becoming negative
  always_comb begin
    {carry, s} = {1'b0, x} + {{CNT_W{1'b0}}, 1'b1};
    overflow   = ~x[CNT_W-1] & s[CNT_W-1];
  end

endmodule

// File: rtl/incr_count_ctrl.sv
// rtl/incr_count_ctrl.sv - start/pause counter FSM with terminal compare, sticky flags and done handshake (optional INCR_COUNT_AUTO_RELOAD_EN)
module incr_count_ctrl
  import incr_count_pkg::*;
#(
  parameter logic [3:0] TERM_DEFAULT = TERM_DEFAULT_VAL,
  parameter int         WIDTH        = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  input  logic             term_sel,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             wrap_seen,
  output logic             ovf_seen
);

  // The incrementer is hard-wired to 4 bits, so any other width cannot be built
  if (WIDTH != CNT_W) begin : g_bad_width
    $error("incr_count_ctrl: WIDTH must equal CNT_W (4)");
  end

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic             done_valid_q;
  logic             wrap_q;
  logic             ovf_q;

  logic [CNT_W-1:0] term;
  logic [CNT_W-1:0] inc_s;
  logic             inc_carry;
  logic             inc_ovf;

  increment_by_1 u_inc (
    .x        (count_q),
    .s        (inc_s),
    .carry    (inc_carry),
    .overflow (inc_ovf)
  );

  // Terminal is re-selected every cycle so mid-run changes apply at once
  always_comb begin
    term = term_sel ? term_val : TERM_DEFAULT;
  end

  // Control FSM; every output is a register updated alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      busy_q       <= 1'b0;
      done_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
`ifdef INCR_COUNT_AUTO_RELOAD_EN
      done_valid_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= COUNT;
            busy_q  <= 1'b1;
            count_q <= load_val;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        COUNT: begin
          if (pause) begin
            state_q <= HOLD;
          end else if (count_q == term) begin
`ifdef INCR_COUNT_AUTO_RELOAD_EN
            count_q      <= load_val;
            done_valid_q <= 1'b1;
`else
            state_q      <= DONE;
            busy_q       <= 1'b0;
            done_valid_q <= 1'b1;
`endif
          end else begin
            count_q <= inc_s;
            wrap_q  <= wrap_q | inc_carry;
            ovf_q   <= ovf_q | inc_ovf;
          end
        end
        HOLD: begin
          if (start) begin
            state_q <= COUNT;
          end
        end
        DONE: begin
          if (done_ready) begin
            state_q      <= IDLE;
            done_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign count      = count_q;
  assign busy       = busy_q;
  assign done_valid = done_valid_q;
  assign wrap_seen  = wrap_q;
  assign ovf_seen   = ovf_q;

endmodule

// File: tb/tb_incr_count_ctrl.sv
// tb/tb_incr_count_ctrl.sv - randomized self-checking bench for incr_count_ctrl against a run-level model
module tb_incr_count_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic [3:0] load_val;
  logic       term_sel;
  logic [3:0] term_val;
  logic [3:0] count;
  logic       busy;
  logic       done_valid;
  logic       done_ready;
  logic       wrap_seen;
  logic       ovf_seen;

  int n_checks = 0;
  int n_errors = 0;

  incr_count_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .load_val   (load_val),
    .term_sel   (term_sel),
    .term_val   (term_val),
    .count      (count),
    .busy       (busy),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .wrap_seen  (wrap_seen),
    .ovf_seen   (ovf_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run: L -> T with optional pauses, then DONE and handshake.
  // Expected values come from modular arithmetic over the run, not a state machine.
  task automatic run(input int l, input int t_in, input bit use_def, input int pause_pct,
                     input int force_at, input int force_len, input int bp);
    int  t, n, k, cur, hl, nb;
    bit  exp_wrap, exp_ovf, forced, fp, finished;
    t = use_def ? 15 : t_in;
    n = (t - l + 16) % 16;
    exp_wrap = 0;
    exp_ovf  = 0;
    for (int i = 0; i < n; i++) begin
      if ((l + i) % 16 == 15) exp_wrap = 1;
      if ((l + i) % 16 == 7)  exp_ovf  = 1;
    end
    load_val   = 4'(l);
    term_sel   = !use_def;
    term_val   = use_def ? 4'($urandom_range(15)) : 4'(t);
    start      = 1'b1;
    pause      = 1'($urandom);
    done_ready = 1'b0;
    tick();
    start = 1'b0;
    pause = 1'b0;
    check("load", count, l);
    check("busy_run", busy, 1);
    check("wrap_clr", wrap_seen, 0);
    check("ovf_clr", ovf_seen, 0);
    k = 0;
    forced = 0;
    finished = 0;
    for (int it = 0; it < 200 && !finished; it++) begin
      cur = (l + k) % 16;
      fp  = (force_at == cur) && !forced;
      if (fp || ($urandom_range(99) < pause_pct)) begin
        hl = fp ? force_len : $urandom_range(1, 4);
        if (fp) forced = 1;
        pause = 1'b1;
        start = 1'b0;
        tick();
        check("pause_hold", count, cur);
        check("pause_busy", busy, 1);
        for (int h = 1; h < hl; h++) begin
          pause = 1'($urandom);
          start = 1'b0;
          tick();
          check("hold", count, cur);
          check("hold_busy", busy, 1);
        end
        pause = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        pause = 1'b0;
        check("resume", count, cur);
        check("resume_busy", busy, 1);
      end else if (k == n) begin
        pause = 1'b0;
        start = 1'($urandom);
        tick();
        start = 1'b0;
        finished = 1;
      end else begin
        pause = 1'b0;
        start = 1'($urandom);
        tick();
        start = 1'b0;
        k++;
        check("inc", count, (l + k) % 16);
        check("dv_low", done_valid, 0);
      end
    end
    check("run_bound", finished, 1);
    check("done_valid", done_valid, 1);
    check("done_count", count, t);
    check("done_busy", busy, 0);
    check("done_wrap", wrap_seen, exp_wrap);
    check("done_ovf", ovf_seen, exp_ovf);
    nb = (bp < 0) ? $urandom_range(0, 5) : bp;
    for (int b = 0; b < nb; b++) begin
      done_ready = 1'b0;
      start = 1'($urandom);
      tick();
      check("bp_valid", done_valid, 1);
      check("bp_count", count, t);
    end
    start = 1'b0;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check("hs_valid", done_valid, 0);
    check("hs_count", count, t);
    check("hs_busy", busy, 0);
    check("hs_wrap", wrap_seen, exp_wrap);
    check("hs_ovf", ovf_seen, exp_ovf);
    // Idle cycle: nothing should move without start, pause is ignored
    pause = 1'($urandom);
    tick();
    pause = 1'b0;
    check("idle_count", count, t);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    pause      = 1'b0;
    load_val   = 4'd0;
    term_sel   = 1'b0;
    term_val   = 4'd0;
    done_ready = 1'b0;
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_dv", done_valid, 0);
    check("rst_wrap", wrap_seen, 0);
    check("rst_ovf", ovf_seen, 0);
    rst_n = 1'b1;
    tick();

    // Directed runs from the test plan
    run(3, 7, 0, 0, -1, 0, 0);
    run(3, 9, 0, 0, -1, 0, 0);
    run(14, 1, 0, 0, -1, 0, 0);
    run(3, 9, 0, 0, 5, 4, 0);
    run(2, 6, 0, 0, -1, 0, 10);
    run(9, 9, 0, 0, -1, 0, 0);
    run(0, 0, 1, 0, -1, 0, 1);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      run($urandom_range(15), $urandom_range(15), 1'($urandom_range(3) == 0), 20, -1, 0, -1);
    end

    // Asynchronous reset mid-COUNT at count 4
    load_val = 4'd0;
    term_sel = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && count != 4'd4; i++) tick();
    check("pre_rst_count", count, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_busy", busy, 0);
    check("arst_dv", done_valid, 0);
    check("arst_wrap", wrap_seen, 0);
    check("arst_ovf", ovf_seen, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_count", count, 0);
    check("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
